// File: rtl/ifu_prefetch.sv
// ifu_prefetch: fetch PC sequencer with a DEPTH-entry {pc, inst, fault} prefetch FIFO feeding decode
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              mem_bus_iaddr,
  input  logic [31:0]              mem_bus_rinst,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc,
  output logic                     inst_fault,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  typedef enum logic [1:0] {BOOT, RUN, FAULT, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc, pc_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic fault_mem [DEPTH];
  logic push, push_fault, pop, empty;
  assign empty = cnt == '0;
  assign mem_bus_iaddr = fetch_pc;
  assign inst_valid = !empty && !redirect_valid;
  assign pop = inst_valid && inst_ready;
  assign fifo_cnt = cnt;
  assign inst_pc = empty ? 32'h0 : pc_mem[rd_ptr];
  assign inst_data = empty ? 32'h0 : data_mem[rd_ptr];
  assign inst_fault = !empty && fault_mem[rd_ptr];
  always_comb begin
    push_fault = state == FAULT;
    push = !redirect_valid && ((state == RUN && fetch_en && (cnt < FULL || pop)) || (push_fault && empty));
    state_nx = redirect_valid ? (redirect_pc[1:0] == 2'b00 ? RUN : FAULT)
             : state == BOOT ? RUN
             : (push_fault && empty) ? HALT
             : state;
    pc_nx = redirect_valid ? redirect_pc : (push && !push_fault) ? fetch_pc + 32'd4 : fetch_pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      fetch_pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      fetch_pc <= pc_nx;
      wr_ptr <= redirect_valid ? '0 : push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= redirect_valid ? '0 : pop ? rd_ptr + AW'(1) : rd_ptr;
      cnt <= redirect_valid ? '0 : cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= fetch_pc;
      data_mem[wr_ptr] <= push_fault ? 32'h0000_0013 : mem_bus_rinst;
      fault_mem[wr_ptr] <= push_fault;
    end
  end
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed scoreboard bench for the fetch unit and its prefetch FIFO
module tb_ifu_prefetch;
  logic clk = 1'b0;
  logic rst, fetch_en, redirect_valid, inst_ready, inst_valid, inst_fault;
  logic [31:0] mem_bus_iaddr, mem_bus_rinst, redirect_pc, inst_data, inst_pc;
  logic [2:0] fifo_cnt;
  int checks = 0;
  int failures = 0;
  logic [64:0] sb [$];
  always #5 clk = ~clk;
  function automatic logic [31:0] memw(input logic [31:0] a);
    return a == 32'h8000_0000 ? 32'h0050_0093 : {a[15:0], a[31:16]} ^ 32'hA5A5_0000;
  endfunction
  assign mem_bus_rinst = memw(mem_bus_iaddr);
  ifu_prefetch dut (
    .clk(clk), .rst(rst), .mem_bus_iaddr(mem_bus_iaddr), .mem_bus_rinst(mem_bus_rinst),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_fault(inst_fault), .fifo_cnt(fifo_cnt)
  );
  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [64:0] ent(input logic [31:0] pc, input logic f);
    return {pc, f ? 32'h0000_0013 : memw(pc), f};
  endfunction
  task automatic exp_run(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) sb.push_back(ent(pc + 32'(4 * i), 1'b0));
  endtask
  task automatic cyc(input logic r, input logic rdy, input logic en, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst = r;
    inst_ready = rdy;
    fetch_en = en;
    redirect_valid = rv;
    redirect_pc = rpc;
    #1;
    if (inst_valid && inst_ready && !rst) begin
      chk("sb_nonempty", 65'(sb.size() != 0), 65'd1);
      if (sb.size() != 0) chk("pop_entry", {inst_pc, inst_data, inst_fault}, sb.pop_front());
    end
  endtask
  initial begin
    rst = 1'b1;
    inst_ready = 1'b0;
    fetch_en = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    exp_run(32'h8000_0000, 5);
    cyc(0, 0, 1, 0, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_iaddr", mem_bus_iaddr, 32'h8000_0000);
    chk("rst_fault", inst_fault, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
    cyc(0, 0, 1, 0, 0);
    chk("c2_iaddr", mem_bus_iaddr, 32'h8000_0000);
    chk("c2_valid", inst_valid, 0);
    cyc(0, 0, 1, 0, 0);
    chk("c3_valid", inst_valid, 1);
    chk("c3_pc", inst_pc, 32'h8000_0000);
    chk("c3_data", inst_data, 32'h0050_0093);
    repeat (10) cyc(0, 0, 1, 0, 0);
    chk("full_cnt", fifo_cnt, 4);
    chk("full_iaddr", mem_bus_iaddr, 32'h8000_0010);
    chk("hold_pc", inst_pc, 32'h8000_0000);
    repeat (5) cyc(0, 1, 1, 0, 0);
    chk("stream_drained", 65'(sb.size()), 0);
    chk("stream_cnt", fifo_cnt, 4);
    exp_run(32'h8000_0100, 3);
    cyc(0, 1, 1, 1, 32'h8000_0100);
    chk("rd_valid", inst_valid, 0);
    cyc(0, 0, 1, 0, 0);
    chk("rd_cnt", fifo_cnt, 0);
    chk("rd_iaddr", mem_bus_iaddr, 32'h8000_0100);
    cyc(0, 1, 1, 0, 0);
    chk("rd_head_valid", inst_valid, 1);
    chk("rd_head_pc", inst_pc, 32'h8000_0100);
    repeat (2) cyc(0, 1, 1, 0, 0);
    chk("rd_drained", 65'(sb.size()), 0);
    sb.push_back(ent(32'h8000_0102, 1'b1));
    cyc(0, 0, 1, 1, 32'h8000_0102);
    cyc(0, 0, 1, 0, 0);
    chk("flt_iaddr", mem_bus_iaddr, 32'h8000_0102);
    cyc(0, 1, 1, 0, 0);
    chk("flt_flag", inst_fault, 1);
    repeat (5) begin
      cyc(0, 1, 1, 0, 0);
      chk("halt_valid", inst_valid, 0);
    end
    exp_run(32'h8000_0200, 1);
    cyc(0, 1, 1, 1, 32'h8000_0200);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("restart_drained", 65'(sb.size()), 0);
    exp_run(32'hFFFF_FFF8, 3);
    cyc(0, 1, 1, 1, 32'hFFFF_FFF8);
    cyc(0, 1, 1, 0, 0);
    repeat (3) cyc(0, 1, 1, 0, 0);
    chk("wrap_drained", 65'(sb.size()), 0);
    repeat (5) cyc(0, 0, 1, 0, 0);
    chk("refill_cnt", fifo_cnt, 4);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("mid_rst_valid", inst_valid, 0);
    chk("mid_rst_cnt", fifo_cnt, 0);
    chk("mid_rst_iaddr", mem_bus_iaddr, 32'h8000_0000);
    exp_run(32'h8000_0000, 1);
    cyc(0, 1, 1, 0, 0);
    chk("boot_valid", inst_valid, 0);
    cyc(0, 1, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("halt_en_cnt", fifo_cnt, 1);
    chk("halt_en_iaddr", mem_bus_iaddr, 32'h8000_0008);
    exp_run(32'h8000_0004, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("drain_cnt", fifo_cnt, 0);
    chk("drain_valid", inst_valid, 0);
    chk("final_drained", 65'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
